// File: rtl/pc_fetch_ctrl.sv
// RV32I fetch controller: owns the PC, drives the instruction-memory request and
// presents one fetched word at a time to decode, with redirect and fault handling.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Redirect_valid,
    input  logic [31:0] Redirect_pc,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ack,
    input  logic [31:0] Imem_rdata,
    output logic        Inst_valid,
    output logic [31:0] Inst,
    output logic [31:0] Inst_pc,
    input  logic        Inst_ready,
    output logic [31:0] Pc,
    output logic        Fault,
    output logic [1:0]  Fault_cause,
    input  logic        Fault_clear
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             redirect_ok;
    logic             redirect_bad;

    function automatic logic [31:0] pc_plus4(input logic [31:0] p);
        return p + 32'd4;
    endfunction

    assign redirect_ok  = Redirect_valid && (Redirect_pc[1:0] == 2'b00);
    assign redirect_bad = Redirect_valid && (Redirect_pc[1:0] != 2'b00);

    // Outputs decode registered state only, so they never glitch on inputs.
    assign Imem_req   = (state == FETCH);
    assign Inst_valid = (state == HOLD);
    assign Fault      = (state == FAULT);
    assign Imem_addr  = Pc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= FETCH;
            Pc          <= RESET_PC;
            Inst        <= 32'h0;
            Inst_pc     <= 32'h0;
            wait_cnt    <= '0;
            Fault_cause <= CAUSE_NONE;
        end else begin
            case (state)
                FETCH, HOLD: begin
                    // Redirect outranks ack, ready and timeout in both live states.
                    if (redirect_ok) begin
                        Pc       <= Redirect_pc;
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end else if (redirect_bad) begin
                        Fault_cause <= CAUSE_MISALIGN;
                        state       <= FAULT;
                    end else if (state == FETCH) begin
                        if (Imem_ack) begin
                            Inst     <= Imem_rdata;
                            Inst_pc  <= Pc;
                            Pc       <= pc_plus4(Pc);
                            wait_cnt <= '0;
                            state    <= HOLD;
                        end else if (wait_cnt == CNT_LAST) begin
                            Fault_cause <= CAUSE_TIMEOUT;
                            state       <= FAULT;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else if (Inst_ready) begin
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end
                end
                FAULT: begin
                    if (Fault_clear) begin
                        Pc          <= RESET_PC;
                        Fault_cause <= CAUSE_NONE;
                        wait_cnt    <= '0;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state    <= FETCH;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed test-plan scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Redirect_valid = 1'b0;
    logic [31:0] Redirect_pc = 32'h0;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack = 1'b0;
    logic [31:0] Imem_rdata = 32'h0;
    logic        Inst_valid;
    logic [31:0] Inst;
    logic [31:0] Inst_pc;
    logic        Inst_ready = 1'b0;
    logic [31:0] Pc;
    logic        Fault;
    logic [1:0]  Fault_cause;
    logic        Fault_clear = 1'b0;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Redirect_valid(Redirect_valid), .Redirect_pc(Redirect_pc),
        .Imem_req(Imem_req), .Imem_addr(Imem_addr),
        .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
        .Inst_valid(Inst_valid), .Inst(Inst), .Inst_pc(Inst_pc), .Inst_ready(Inst_ready),
        .Pc(Pc), .Fault(Fault), .Fault_cause(Fault_cause), .Fault_clear(Fault_clear)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        req;
        logic        vld;
        logic        flt;
        logic [1:0]  cause;
        logic [31:0] pc;
    } status_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } inst_t;

    status_t status_q[$];
    inst_t   inst_q[$];
    int      checks = 0;
    int      failures = 0;

    // Reference model: what the controller is doing, in transaction terms.
    logic [31:0] m_pc;
    bit          m_holding;
    bit          m_faulted;
    logic [1:0]  m_cause;
    int          m_waited;

    task automatic model_reset();
        m_pc = RESET_PC;
        m_holding = 0;
        m_faulted = 0;
        m_cause = 2'b00;
        m_waited = 0;
    endtask

    task automatic model_step(input bit rv, input logic [31:0] rpc, input bit ack,
                              input logic [31:0] rd, input bit rdy, input bit fc);
        inst_t it;
        if (m_faulted) begin
            if (fc) begin
                m_faulted = 0;
                m_cause = 2'b00;
                m_pc = RESET_PC;
                m_waited = 0;
            end
        end else if (rv) begin
            if (rpc[1:0] == 2'b00) begin
                m_pc = rpc;
                m_holding = 0;
                m_waited = 0;
            end else begin
                m_faulted = 1;
                m_holding = 0;
                m_cause = 2'b01;
            end
        end else if (m_holding) begin
            if (rdy) begin
                m_holding = 0;
                m_waited = 0;
            end
        end else if (ack) begin
            it.pc = m_pc;
            it.word = rd;
            inst_q.push_back(it);
            m_pc = m_pc + 32'd4;
            m_holding = 1;
            m_waited = 0;
        end else if (m_waited == MAX_WAIT) begin
            m_faulted = 1;
            m_cause = 2'b10;
        end else begin
            m_waited++;
        end
    endtask

    // Called at a negedge; applies one cycle of inputs and returns at the next negedge.
    task automatic drive(input bit rv, input logic [31:0] rpc, input bit ack,
                         input logic [31:0] rd, input bit rdy, input bit fc);
        status_t s;
        Redirect_valid = rv;
        Redirect_pc = rpc;
        Imem_ack = ack;
        Imem_rdata = rd;
        Inst_ready = rdy;
        Fault_clear = fc;
        model_step(rv, rpc, ack, rd, rdy, fc);
        s.req = !m_faulted && !m_holding;
        s.vld = m_holding;
        s.flt = m_faulted;
        s.cause = m_cause;
        s.pc = m_pc;
        status_q.push_back(s);
        @(negedge Clk);
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 32'h0, 1'b0, 32'h0, rdy, 1'b0);
    endtask

    task automatic fetch_word(input bit rdy);
        drive(1'b0, 32'h0, 1'b1, m_pc ^ KEY, rdy, 1'b0);
    endtask

    // Monitor: compares status every cycle and each newly presented instruction.
    bit      prev_vld = 0;
    status_t e;
    inst_t   ei;
    always @(posedge Clk) begin
        #2;
        if (!Reset_n) begin
            prev_vld = 0;
        end else begin
            checks++;
            if (status_q.size() == 0) begin
                failures++;
                $display("FAIL status_underflow t=%0t: no expectation queued", $time);
            end else begin
                e = status_q.pop_front();
                if (Imem_req !== e.req || Inst_valid !== e.vld || Fault !== e.flt ||
                    Fault_cause !== e.cause || Pc !== e.pc || Imem_addr !== e.pc) begin
                    failures++;
                    $display("FAIL status t=%0t got req=%b vld=%b flt=%b cause=%b pc=%h addr=%h required req=%b vld=%b flt=%b cause=%b pc=%h",
                             $time, Imem_req, Inst_valid, Fault, Fault_cause, Pc, Imem_addr,
                             e.req, e.vld, e.flt, e.cause, e.pc);
                end
            end
            if (Inst_valid && !prev_vld) begin
                checks++;
                if (inst_q.size() == 0) begin
                    failures++;
                    $display("FAIL inst_unexpected t=%0t got pc=%h inst=%h", $time, Inst_pc, Inst);
                end else begin
                    ei = inst_q.pop_front();
                    if (Inst_pc !== ei.pc || Inst !== ei.word) begin
                        failures++;
                        $display("FAIL inst t=%0t got pc=%h inst=%h required pc=%h inst=%h",
                                 $time, Inst_pc, Inst, ei.pc, ei.word);
                    end
                end
            end
            prev_vld = Inst_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int starve;
        bit rv, ack;
        logic [31:0] rpc;

        model_reset();
        #1 Reset_n = 1'b0;
        #1;
        check("reset_req", {31'h0, Imem_req}, 32'h1);
        check("reset_valid", {31'h0, Inst_valid}, 32'h0);
        check("reset_fault", {29'h0, Fault, Fault_cause}, 32'h0);
        check("reset_pc", Pc, RESET_PC);
        check("reset_inst", Inst, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Sequential fetch, one word every two cycles.
        for (int i = 0; i < 4; i++) begin
            fetch_word(1'b1);
            idle(1'b1);
        end

        // Backpressure for five cycles, then release.
        fetch_word(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Redirect colliding with an ack: the ack is discarded.
        drive(1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        fetch_word(1'b0);
        idle(1'b1);

        // Misaligned redirect, then clear.
        drive(1'b1, 32'h0000_0102, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0200, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b0);

        // Timeout: 16 request cycles with no ack, then ack on index 15.
        drive(1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < MAX_WAIT + 1; i++) idle(1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < MAX_WAIT; i++) idle(1'b0);
        fetch_word(1'b0);
        idle(1'b1);

        // PC wrap, then asynchronous reset in HOLD.
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
        fetch_word(1'b0);
        #1;
        check("pre_reset_valid", {31'h0, Inst_valid}, 32'h1);
        check("wrap_pc", Pc, 32'h0);
        Reset_n = 1'b0;
        #1;
        check("async_reset_valid", {31'h0, Inst_valid}, 32'h0);
        check("async_reset_pc", Pc, RESET_PC);
        check("async_reset_req", {31'h0, Imem_req}, 32'h1);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;

        // Randomized traffic.
        starve = 0;
        for (int i = 0; i < 3000; i++) begin
            if (starve == 0 && $urandom_range(0, 60) == 0) starve = $urandom_range(10, 20);
            rv = ($urandom_range(0, 15) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            ack = (starve == 0) && ($urandom_range(0, 9) < 6);
            if (starve > 0) starve--;
            drive(rv, rpc, ack, $urandom, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 3) == 0));
        end

        #1;
        check("status_queue_drained", status_q.size(), 32'h0);
        check("inst_queue_drained", inst_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
